cu_multicycle: RTL and testbench

Multicycle control unit for the RV32I-subset processor; successor to the single-cycle `cu`. It sequences each instruction through fetch/decode/execute/memory/writeback states, holds the shared memory port through a req/ready handshake with a timeout, and raises a sticky fault on illegal opcodes or memory timeouts. It sits between the instruction register and the datapath's mux selects and write strobes.

---
 rtl/cu_multicycle.sv | 254 +++++++++++++++++++++++++
 tb/tb_cu_multicycle.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_multicycle.sv
// cu_multicycle: multicycle control unit for the RV32I-subset core.
// Sequences fetch/decode/execute/memory/writeback, owns the shared memory
// port through a req/ready handshake guarded by a wait-cycle timeout, and
// parks in a sticky FAULT state on illegal opcodes or memory timeouts.
// Optional feature macro: CU_MULDIV_EN adds the mul_start/mul_done handshake
// and the MULWAIT state for funct7=0000001 R-type instructions.
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC+4
// DECODE  | dispatch on opcode, precompute branch target
// EXEC_R  | register-register ALU op
// EXEC_I  | register-immediate ALU op, lui
// MEMADR  | effective address rs1+imm
// MEMRD   | load access
// MEMWR   | store access
// WB      | register file write
// BRANCH  | compare rs1/rs2, conditionally take target
// JAL     | link old PC+4, jump to target
// FAULT   | sticky error, left only by reset
// MULWAIT | wait for external multiplier/divider
module cu_multicycle #(
  parameter int ILEN        = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMEOUT_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ILEN-1:0] instr,
  input  logic            branch_taken,
  input  logic            mem_ready,
`ifdef CU_MULDIV_EN
  input  logic            mul_done,
  output logic            mul_start,
`endif
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_sel,
  output logic            pc_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [3:0]      alu_op,
  output logic [2:0]      imm_sel,
  output logic [1:0]      result_src,
  output logic            fault,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_MEMADR  = 4'd4,
    S_MEMRD   = 4'd5,
    S_MEMWR   = 4'd6,
    S_WB      = 4'd7,
    S_BRANCH  = 4'd8,
    S_JAL     = 4'd9,
    S_FAULT   = 4'd10,
    S_MULWAIT = 4'd11
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 waiting;
  logic                 timed_out;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic                 is_mul;
  logic                 unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign is_mul       = (opcode == OP_R) && (funct7 == 7'b0000001);
  assign unused_instr = ^{instr[24:15], instr[11:7]};
  // The counter may sit at MEM_TIMEOUT for one cycle; a ready in that cycle still completes.
  assign timed_out    = (cnt_q == TIMEOUT_W'(MEM_TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Wait-cycle counter: cleared on every state change, counts stalled cycles otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else if (waiting)           cnt_q <= cnt_q + TIMEOUT_W'(1);
  end

  // Next-state and output decode; all outputs are held at 0 while reset is asserted.
  always_comb begin
    state_d    = state_q;
    waiting    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 4'b0000;
    imm_sel    = 3'b000;
    result_src = 2'b00;
    fault      = 1'b0;
    state      = state_q;
`ifdef CU_MULDIV_EN
    mul_start  = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          waiting = 1'b1;
          if (timed_out) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_sel   = 3'b010;
        case (opcode)
`ifdef CU_MULDIV_EN
          OP_R:             state_d = is_mul ? S_MULWAIT : S_EXEC_R;
`else
          OP_R:             state_d = is_mul ? S_FAULT : S_EXEC_R;
`endif
          OP_I, OP_LUI:     state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_BR:            state_d = S_BRANCH;
          OP_JAL:           state_d = S_JAL;
          default:          state_d = S_FAULT;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = {instr[30], funct3};
        state_d   = S_WB;
      end
      S_EXEC_I: begin
        alu_src_b = 2'b01;
        if (opcode == OP_LUI) begin
          alu_src_a = 2'b11;
          imm_sel   = 3'b100;
        end else begin
          alu_src_a = 2'b10;
          alu_op    = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
        end
        state_d = S_WB;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_sel   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
        state_d   = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req    = 1'b1;
        mem_sel    = 1'b1;
        result_src = 2'b01;
        if (mem_ready) state_d = S_WB;
        else begin
          waiting = 1'b1;
          if (timed_out) state_d = S_FAULT;
        end
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        mem_sel = 1'b1;
        if (mem_ready) state_d = S_FETCH;
        else begin
          waiting = 1'b1;
          if (timed_out) state_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        if (opcode == OP_LOAD) result_src = 2'b01;
`ifdef CU_MULDIV_EN
        else if (is_mul)       result_src = 2'b10;
`endif
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 4'b1000;
        pc_write  = branch_taken;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // ALU recomputes old PC+4 for the link; the target comes from the ALU out register.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_sel   = 3'b011;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
`ifdef CU_MULDIV_EN
      S_MULWAIT: begin
        mul_start = 1'b1;
        if (mul_done) state_d = S_WB;
        else begin
          waiting = 1'b1;
          if (timed_out) state_d = S_FAULT;
        end
      end
`endif
      default: state_d = S_FAULT;
    endcase
    if (!reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_sel    = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 4'b0000;
      imm_sel    = 3'b000;
      result_src = 2'b00;
      fault      = 1'b0;
      state      = 4'd0;
`ifdef CU_MULDIV_EN
      mul_start  = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed bench for cu_multicycle (default build, CU_MULDIV_EN undefined).
module tb_cu_multicycle;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_sel, pc_write, ir_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [3:0]  alu_op;
  logic [2:0]  imm_sel;
  logic        fault;
  logic [3:0]  state;
  logic [5:0]  strb;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [31:0] I_ANDI = 32'hFFF0F093;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_MUL  = 32'h022081B3;

  cu_multicycle #(.ILEN(32), .MEM_TIMEOUT(15), .TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_sel(imm_sel), .result_src(result_src), .fault(fault), .state(state)
  );

  // {mem_req, mem_we, mem_sel, pc_write, ir_write, reg_write}
  assign strb = {mem_req, mem_we, mem_sel, pc_write, ir_write, reg_write};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; instr = I_ADD; mem_ready = 1'b1; branch_taken = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_strb", strb, 0);
    chk("rst_fault", fault, 0);
    chk("rst_srcb", alu_src_b, 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    // add
    chk("add_fetch_state", state, 0);
    chk("add_fetch_strb", strb, 6'b100110);
    chk("add_fetch_srcb", alu_src_b, 2);
    tick();
    chk("add_dec_state", state, 1);
    chk("add_dec_srca", alu_src_a, 1);
    chk("add_dec_srcb", alu_src_b, 1);
    chk("add_dec_imm", imm_sel, 2);
    chk("add_dec_strb", strb, 0);
    tick();
    chk("add_exec_state", state, 2);
    chk("add_exec_srca", alu_src_a, 2);
    chk("add_exec_srcb", alu_src_b, 0);
    chk("add_exec_op", alu_op, 0);
    chk("add_exec_strb", strb, 0);
    tick();
    chk("add_wb_state", state, 7);
    chk("add_wb_strb", strb, 6'b000001);
    chk("add_wb_res", result_src, 0);
    tick();
    chk("add_done_state", state, 0);
    // sub
    instr = I_SUB;
    tick(); tick();
    chk("sub_exec_state", state, 2);
    chk("sub_exec_op", alu_op, 4'b1000);
    tick(); tick();
    // srai
    instr = I_SRAI;
    tick(); tick();
    chk("srai_state", state, 3);
    chk("srai_op", alu_op, 4'b1101);
    chk("srai_srca", alu_src_a, 2);
    chk("srai_srcb", alu_src_b, 1);
    chk("srai_imm", imm_sel, 0);
    tick();
    chk("srai_wb_strb", strb, 6'b000001);
    chk("srai_wb_res", result_src, 0);
    tick();
    // andi with bit30 set: alt bit must not leak into non-shift ops
    instr = I_ANDI;
    tick(); tick();
    chk("andi_op", alu_op, 4'b0111);
    tick(); tick();
    // lui
    instr = I_LUI;
    tick(); tick();
    chk("lui_state", state, 3);
    chk("lui_srca", alu_src_a, 3);
    chk("lui_imm", imm_sel, 4);
    chk("lui_op", alu_op, 0);
    tick(); tick();
    chk("lui_done_state", state, 0);
    // load, after a long fetch stall that must not carry over into MEMRD
    instr = I_LW; mem_ready = 1'b0;
    repeat (14) tick();
    chk("lw_fetch_wait_state", state, 0);
    chk("lw_fetch_wait_strb", strb, 6'b100000);
    mem_ready = 1'b1;
    tick();
    chk("lw_dec_state", state, 1);
    mem_ready = 1'b0;
    tick();
    chk("lw_madr_state", state, 4);
    chk("lw_madr_srca", alu_src_a, 2);
    chk("lw_madr_srcb", alu_src_b, 1);
    chk("lw_madr_imm", imm_sel, 0);
    tick();
    chk("lw_rd1_state", state, 5);
    chk("lw_rd1_strb", strb, 6'b101000);
    tick();
    chk("lw_rd2_strb", strb, 6'b101000);
    tick();
    chk("lw_rd3_strb", strb, 6'b101000);
    mem_ready = 1'b1;
    #1;
    chk("lw_rd4_state", state, 5);
    chk("lw_rd4_strb", strb, 6'b101000);
    tick();
    chk("lw_wb_state", state, 7);
    chk("lw_wb_strb", strb, 6'b000001);
    chk("lw_wb_res", result_src, 1);
    tick();
    chk("lw_done_state", state, 0);
    // store, zero-wait
    instr = I_SW;
    tick(); tick();
    chk("sw_madr_imm", imm_sel, 1);
    tick();
    chk("sw_wr_state", state, 6);
    chk("sw_wr_strb", strb, 6'b111000);
    tick();
    chk("sw_done_state", state, 0);
    // store interrupted by reset
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("swr_wr_state", state, 6);
    tick();
    chk("swr_wr_hold_strb", strb, 6'b111000);
    #2;
    reset = 1'b0;
    #1;
    chk("swr_rst_strb", strb, 0);
    chk("swr_rst_state", state, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("swr_rel_state", state, 0);
    chk("swr_rel_strb", strb, 6'b100000);
    // beq not taken, then taken
    instr = I_BEQ; mem_ready = 1'b1; branch_taken = 1'b0;
    tick(); tick();
    chk("beq_nt_state", state, 8);
    chk("beq_nt_strb", strb, 0);
    chk("beq_nt_op", alu_op, 4'b1000);
    chk("beq_nt_srca", alu_src_a, 2);
    tick();
    chk("beq_nt_done", state, 0);
    branch_taken = 1'b1;
    tick(); tick();
    chk("beq_t_strb", strb, 6'b000100);
    tick();
    chk("beq_t_done", state, 0);
    branch_taken = 1'b0;
    // jal
    instr = I_JAL;
    tick(); tick();
    chk("jal_state", state, 9);
    chk("jal_strb", strb, 6'b000101);
    chk("jal_res", result_src, 0);
    tick();
    chk("jal_done", state, 0);
    // ready in the cycle the counter sits at MEM_TIMEOUT wins; then illegal opcode
    instr = I_ILL; mem_ready = 1'b0;
    repeat (15) tick();
    chk("tob_wait_state", state, 0);
    mem_ready = 1'b1;
    #1;
    chk("tob_ready_strb", strb, 6'b100110);
    tick();
    chk("tob_dec_state", state, 1);
    branch_taken = 1'b1;
    tick();
    chk("ill_state", state, 10);
    chk("ill_fault", fault, 1);
    chk("ill_strb", strb, 0);
    repeat (3) tick();
    chk("ill_sticky_state", state, 10);
    chk("ill_sticky_fault", fault, 1);
    branch_taken = 1'b0;
    reset = 1'b0;
    #1;
    chk("ill_rst_state", state, 0);
    chk("ill_rst_fault", fault, 0);
    tick();
    // pure fetch timeout
    reset = 1'b1; instr = I_ADD; mem_ready = 1'b0;
    repeat (15) tick();
    chk("to_pre_state", state, 0);
    tick();
    chk("to_state", state, 10);
    chk("to_fault", fault, 1);
    chk("to_strb", strb, 0);
    // mul encoding is illegal without the muldiv option
    reset = 1'b0;
    #1;
    chk("mul_rst_fault", fault, 0);
    tick();
    reset = 1'b1; instr = I_MUL; mem_ready = 1'b1;
    tick();
    chk("mul_dec_state", state, 1);
    tick();
    chk("mul_fault_state", state, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
